mult_accum: RTL and testbench
=============================

MULT_ACCUM -- requirements
Module: mult_accum

Interface
REQ-001 Parameter: ACC_W, 12, accumulator and result width in bits.
REQ-002 Parameter: MAX_TERMS, 16, maximum products per accumulation group.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst_n  input  1  reset, asynchronous and active-low.
REQ-005 Port: in_valid  input  1  in_prod/in_last valid this cycle.
REQ-006 Port: in_ready  output  1  block can accept a product this cycle.
REQ-007 Port: in_prod  input  8  unsigned 8-bit product from the upstream 4x4 multiplier.
REQ-008 Port: in_last  input  1  accepted product closes the current group.
REQ-009 Port: out_valid  output  1  out_sum/out_count hold a completed group.
REQ-010 Port: out_ready  input  1  downstream accepts the result this cycle.
REQ-011 Port: out_sum  output  ACC_W  unsigned sum of the group's products.
REQ-012 Port: out_count  output  5  number of products in the group, 1..MAX_TERMS.

Function
REQ-013 Input transfer SHALL occur only on a cycle with in_valid=1 and in_ready=1; output transfer only on a cycle with out_valid=1 and out_ready=1.
REQ-014 The state machine SHALL have three states: IDLE (empty), ACC (partial group held), HOLD (result presented).
REQ-015 in_ready SHALL be 1 in IDLE and ACC and 0 in HOLD; out_valid SHALL be 1 only in HOLD.
REQ-016 IDLE, input transfer with in_last=0: acc := in_prod, count := 1, go to ACC.
REQ-017 IDLE or ACC, input transfer with in_last=1 or count+1 = MAX_TERMS: out_sum := acc+in_prod (acc taken as 0 in IDLE), out_count := count+1, go to HOLD on the next edge.
REQ-018 ACC, input transfer otherwise: acc := acc+in_prod, count := count+1, stay in ACC.
REQ-019 HOLD, output transfer: clear acc and count, go to IDLE; no input accepted in that cycle.
REQ-020 HOLD without out_ready: out_sum, out_count, out_valid SHALL stay stable until transfer.
REQ-021 No input transfer in IDLE/ACC: state, acc, count unchanged (bubbles allowed mid-group).
REQ-022 Latency: result SHALL appear with out_valid=1 on the cycle after the closing input transfer.
REQ-023 Additions are unsigned, width ACC_W; with defaults the maximum sum 16*225=3600 fits in 12 bits, so no overflow handling is needed.
REQ-024 Throughput: minimum group turnaround is group length + 1 cycles (one HOLD cycle).
REQ-025 Inputs are ignored whenever in_valid=0, regardless of in_prod/in_last values.

Reset
REQ-026 rst_n=0 SHALL asynchronously force state IDLE, acc=0, count=0, out_sum=0, out_count=0, out_valid=0, in_ready=1 after release.
REQ-027 Reset asserted mid-group or in HOLD SHALL discard the partial or pending result; no output transfer follows.
REQ-028 First input transfer is possible on the first rising edge after rst_n deasserts.

Structure
REQ-029 Shared package holds ACC_W, MAX_TERMS defaults and the IDLE/ACC/HOLD state encoding.
REQ-030 No sub-module is instantiated; the multiplier stays upstream and the ACC_W-bit add is inline.
REQ-031 One registered state, one accumulator, one counter, one output register pair; outputs driven from registers only.

Verification
REQ-032 Group {3,5,7} with in_last on 7, out_ready=1 -> out_sum=15, out_count=3, out_valid high one cycle after 7 accepted.
REQ-033 16 products of 225 with in_last=0 -> auto-close: out_sum=3600, out_count=16.
REQ-034 Single product 9 with in_last=1 from IDLE -> out_sum=9, out_count=1; in_ready=0 during HOLD.
REQ-035 out_ready=0 for 5 cycles in HOLD -> out_sum/out_count stable, in_valid pulses ignored, transfer on 6th cycle then IDLE.
REQ-036 Group {10,20} with bubbles between, rst_n pulsed low after 20 -> out_valid=0, next group {4} gives out_sum=4.

Source files
------------

// File: rtl/mult_accum_pkg.sv
// Shared definitions for the product accumulator: default sizes and FSM encoding.
package mult_accum_pkg;

  localparam int ACC_W_DEF     = 12;
  localparam int MAX_TERMS_DEF = 16;
  localparam int CNT_W         = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  // Term count after accepting one more product; an empty block starts from zero.
  function automatic logic [CNT_W-1:0] next_count(input state_e st,
                                                  input logic [CNT_W-1:0] cnt);
    logic [CNT_W-1:0] base;
    if (st == ST_ACC) begin
      base = cnt;
    end else begin
      base = {CNT_W{1'b0}};
    end
    return base + 5'd1;
  endfunction

endpackage

// File: rtl/mult_accum.sv
// Accumulates groups of 8-bit products from an upstream multiplier and presents
// each group's sum and term count through a valid/ready output handshake.
module mult_accum
  import mult_accum_pkg::*;
#(
  parameter int ACC_W     = ACC_W_DEF,
  parameter int MAX_TERMS = MAX_TERMS_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_prod,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [4:0]       out_count
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_TERMS);

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [ACC_W-1:0] out_sum_q, out_sum_d;
  logic [4:0]       out_count_q, out_count_d;

  logic [ACC_W-1:0] base_acc_s;
  logic [ACC_W-1:0] sum_s;
  logic [CNT_W-1:0] cnt_next_s;
  logic             in_fire_s;

  // Next-state, accumulator and result computation for the IDLE/ACC/HOLD machine.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    count_d     = count_q;
    out_sum_d   = out_sum_q;
    out_count_d = out_count_q;

    in_fire_s  = in_valid && (state_q != ST_HOLD);
    cnt_next_s = next_count(state_q, count_q);
    if (state_q == ST_ACC) begin
      base_acc_s = acc_q;
    end else begin
      base_acc_s = {ACC_W{1'b0}};
    end
    sum_s = base_acc_s + ACC_W'(in_prod);

    case (state_q)
      ST_IDLE, ST_ACC: begin
        if (in_fire_s) begin
          if (in_last || (cnt_next_s == MAX_CNT)) begin
            // Closing product: latch the result; acc/count are cleared on hand-off.
            out_sum_d   = sum_s;
            out_count_d = cnt_next_s;
            state_d     = ST_HOLD;
          end else begin
            acc_d   = sum_s;
            count_d = cnt_next_s;
            state_d = ST_ACC;
          end
        end else begin
          state_d = state_q;
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          acc_d   = {ACC_W{1'b0}};
          count_d = {CNT_W{1'b0}};
          state_d = ST_IDLE;
        end else begin
          state_d = ST_HOLD;
        end
      end
      default: begin
        acc_d   = {ACC_W{1'b0}};
        count_d = {CNT_W{1'b0}};
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, accumulator, counter and result registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      acc_q       <= {ACC_W{1'b0}};
      count_q     <= {CNT_W{1'b0}};
      out_sum_q   <= {ACC_W{1'b0}};
      out_count_q <= 5'd0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      count_q     <= count_d;
      out_sum_q   <= out_sum_d;
      out_count_q <= out_count_d;
    end
  end

  // Handshake flags are pure decodes of the state register.
  assign out_valid = (state_q == ST_HOLD);
  assign in_ready  = (state_q != ST_HOLD);
  assign out_sum   = out_sum_q;
  assign out_count = out_count_q;

endmodule

// File: tb/tb_mult_accum.sv
// Directed self-checking bench for mult_accum.
module tb_mult_accum;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_prod;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] out_sum;
  logic [4:0]  out_count;

  int n_checks = 0;
  int n_fail   = 0;

  mult_accum #(.ACC_W(12), .MAX_TERMS(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_prod   (in_prod),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_count (out_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one product, waiting (bounded) for in_ready.
  task automatic send(input logic [7:0] p, input logic l);
    int waits;
    waits = 0;
    while (in_ready !== 1'b1 && waits < 20) begin
      step();
      waits++;
    end
    if (waits >= 20) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: in_ready=%b required 1", in_ready);
    end
    in_valid = 1'b1;
    in_prod  = p;
    in_last  = l;
    step();
    in_valid = 1'b0;
    in_prod  = 8'd0;
    in_last  = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_prod = 8'd0; in_last = 1'b0; out_ready = 1'b0;
    step(); step();
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b required 0", out_valid); end
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b required 1", in_ready); end
    n_checks++;
    if (out_sum !== 12'd0 || out_count !== 5'd0) begin
      n_fail++; $display("FAIL reset_result: got sum=%0d cnt=%0d required 0/0", out_sum, out_count);
    end
    #3 rst_n = 1'b1;
  endtask

  // Single closing product straight out of reset (first edge after release).
  task automatic test_single();
    send(8'd9, 1'b1);
    n_checks++;
    if (out_valid !== 1'b1 || out_sum !== 12'd9 || out_count !== 5'd1) begin
      n_fail++; $display("FAIL single: got v=%b sum=%0d cnt=%0d required 1/9/1", out_valid, out_sum, out_count);
    end
    n_checks++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL single_hold_ready: got %b required 0", in_ready); end
    out_ready = 1'b1;
    step();
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL single_drain: got v=%b rdy=%b required 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_basic_group();
    out_ready = 1'b1;
    send(8'd3, 1'b0);
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_partial: got v=%b required 0", out_valid); end
    send(8'd5, 1'b0);
    send(8'd7, 1'b1);
    n_checks++;
    if (out_valid !== 1'b1 || out_sum !== 12'd15 || out_count !== 5'd3) begin
      n_fail++; $display("FAIL basic_group: got v=%b sum=%0d cnt=%0d required 1/15/3", out_valid, out_sum, out_count);
    end
    step();
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_drain: got v=%b required 0", out_valid); end
  endtask

  task automatic test_auto_close();
    out_ready = 1'b1;
    for (int i = 0; i < 15; i++) send(8'd225, 1'b0);
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL auto_15: got v=%b required 0", out_valid); end
    send(8'd225, 1'b0);
    n_checks++;
    if (out_valid !== 1'b1 || out_sum !== 12'd3600 || out_count !== 5'd16) begin
      n_fail++; $display("FAIL auto_close: got v=%b sum=%0d cnt=%0d required 1/3600/16", out_valid, out_sum, out_count);
    end
    step();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    send(8'd1, 1'b0);
    send(8'd2, 1'b1);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_prod = 8'd99; in_last = 1'b1;
      step();
      n_checks++;
      if (out_valid !== 1'b1 || out_sum !== 12'd3 || out_count !== 5'd2 || in_ready !== 1'b0) begin
        n_fail++; $display("FAIL bp_stable[%0d]: got v=%b sum=%0d cnt=%0d rdy=%b required 1/3/2/0",
                           i, out_valid, out_sum, out_count, in_ready);
      end
    end
    out_ready = 1'b1;
    step();
    in_valid = 1'b0; in_prod = 8'd0; in_last = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL bp_transfer: got v=%b rdy=%b required 0/1", out_valid, in_ready);
    end
    send(8'd4, 1'b1);
    n_checks++;
    if (out_sum !== 12'd4 || out_count !== 5'd1) begin
      n_fail++; $display("FAIL bp_after: got sum=%0d cnt=%0d required 4/1", out_sum, out_count);
    end
    step();
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    send(8'd1, 1'b1);
    n_checks++;
    if (out_sum !== 12'd1 || out_count !== 5'd1) begin
      n_fail++; $display("FAIL b2b_first: got sum=%0d cnt=%0d required 1/1", out_sum, out_count);
    end
    send(8'd2, 1'b0);
    send(8'd3, 1'b1);
    n_checks++;
    if (out_valid !== 1'b1 || out_sum !== 12'd5 || out_count !== 5'd2) begin
      n_fail++; $display("FAIL b2b_second: got v=%b sum=%0d cnt=%0d required 1/5/2", out_valid, out_sum, out_count);
    end
    step();
  endtask

  task automatic test_reset_mid_group();
    out_ready = 1'b1;
    send(8'd10, 1'b0);
    in_valid = 1'b0; in_prod = 8'd200; in_last = 1'b1;
    step(); step();
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL bubble_ignored: got v=%b rdy=%b required 0/1", out_valid, in_ready);
    end
    in_prod = 8'd0; in_last = 1'b0;
    send(8'd20, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL mid_reset_async: got v=%b rdy=%b required 0/1", out_valid, in_ready);
    end
    #2 rst_n = 1'b1;
    step();
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_reset_no_out: got v=%b required 0", out_valid); end
    send(8'd4, 1'b1);
    n_checks++;
    if (out_valid !== 1'b1 || out_sum !== 12'd4 || out_count !== 5'd1) begin
      n_fail++; $display("FAIL mid_reset_next: got v=%b sum=%0d cnt=%0d required 1/4/1", out_valid, out_sum, out_count);
    end
    step();
  endtask

  task automatic test_reset_hold();
    out_ready = 1'b0;
    send(8'd50, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || out_sum !== 12'd0 || out_count !== 5'd0) begin
      n_fail++; $display("FAIL hold_reset: got v=%b sum=%0d cnt=%0d required 0/0/0", out_valid, out_sum, out_count);
    end
    #2 rst_n = 1'b1;
    out_ready = 1'b1;
    step();
  endtask

  initial begin
    test_reset();
    test_single();
    test_basic_group();
    test_auto_close();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_group();
    test_reset_hold();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
